sd_adc_decim: RTL and testbench
===============================

Name: sd_adc_decim

Overview:
- First-order delta-sigma ADC receiver: the counterpart to the team's 1-bit delta-sigma DAC.
- An external comparator (LVDS pair or RC + input pin) feeds AdcIn. The block registers it and drives the feedback pin FbOut, closing the modulator loop through an external RC.
- It decimates the resulting bitstream into OUT_W-bit unsigned samples on a valid/ready interface.
- Used for audio/paddle sampling next to the DAC path, in the same clock domain.

Parameters:
- LOG2_DECIM, 8, log2 of the decimation ratio; DECIM = 2^LOG2_DECIM bitstream clocks per output sample (legal 2..12).
- OUT_W, LOG2_DECIM, output sample width (fixed equal to LOG2_DECIM; exposed for width checks only).

Ports:
- Clk  input  1  system clock; all logic is on its rising edge.
- Reset  input  1  asynchronous, active-low reset; Reset=0 clears all state immediately.
- AdcIn  input  1  raw comparator output, asynchronous to Clk.
- FbOut  output  1  feedback bit driven to the external RC integrator.
- Sample  output  OUT_W  decimated unsigned sample.
- SampleValid  output  1  Sample holds an unconsumed value.
- SampleReady  input  1  consumer accepts Sample when SampleValid=1 and SampleReady=1 on a rising edge.
- Overrun  output  1  one-cycle pulse when an unconsumed sample is overwritten.

Behaviour:
- Reset values: FbOut=0, Sample=0, SampleValid=0, Overrun=0. Synchronizer, counters and integrators = 0.
- Input path: 2-flop synchronizer s1 -> s2. The bitstream bit b = s2.
- Feedback: FbOut <= s2 every cycle, so FbOut lags AdcIn by 3 clocks. FbOut is never gated, including while SampleValid=1.
- Phase counter PhCnt, LOG2_DECIM bits: increments every cycle and wraps from DECIM-1 to 0. Terminal cycle TC = (PhCnt==DECIM-1).
- Accumulator Acc, LOG2_DECIM+1 bits:
  - Non-TC cycle: Acc <= Acc + b.
  - TC cycle: the window result R = Acc + b (includes the current bit), then Acc <= 0.
- Saturation: R lies in 0..DECIM. R=DECIM maps to 2^OUT_W-1; otherwise Sample = R[OUT_W-1:0].
- Output register update on a TC cycle: Sample <= sat(R) and SampleValid <= 1.
- First sample appears DECIM+3 cycles after reset release; later samples follow every DECIM cycles.
- Handshake:
  - Non-TC cycle with SampleValid=1 and SampleReady=1: SampleValid <= 0.
  - TC cycle with SampleValid=1 and SampleReady=1: the new sample loads and SampleValid stays 1. No overrun.
  - TC cycle with SampleValid=1 and SampleReady=0: Sample is overwritten and Overrun=1 for that cycle only.
  - Sample is stable while SampleValid=1 and no TC occurs.
- Constant input: all-ones input -> 2^OUT_W-1 each window; all-zeros -> 0.
- Reset asserted mid-window: the partial window is discarded. Counting restarts from PhCnt=0 after release, and no partial sample is emitted.

Optional Feature:
- Macro: SD_ADC_SINC2_EN.
- Defined: a second-order CIC replaces the boxcar accumulator.
  - Two integrators of 2*LOG2_DECIM+1 bits each, running every cycle (I1 += b, I2 += I1).
  - On TC: two comb stages with one-sample delay. C = I2 - 2*I2[n-1] + I2[n-2], in range 0..DECIM².
  - Output: Sample = min(C, DECIM²-1) >> LOG2_DECIM.
  - The first two TC outputs after reset are suppressed (SampleValid stays 0) until the combs settle. The first valid sample therefore arrives at 3*DECIM+3 cycles.
  - Handshake, Overrun and FbOut behaviour are unchanged.
- Undefined: first-order boxcar as described in Behaviour.

Decomposition:
- Shared package/include: decimation constants (LOG2_DECIM default, DECIM, accumulator/CIC width expressions), saturation width helper, and the SD_ADC_SINC2_EN default comment. These are shared with the DAC's width macros.
- One sub-module: sd_sync2, the 2-flop synchronizer with async active-low reset. It is reused for other asynchronous pins.
- Decimator and handshake stay in the top module.

Test Plan:
- Hold AdcIn=1 with LOG2_DECIM=4 and SampleReady=1 -> first SampleValid at cycle 19 after reset release, Sample=15, then every 16 cycles. FbOut=1 from cycle 3.
- AdcIn toggling 1,0,1,0 with LOG2_DECIM=4 -> Sample=8 every window. FbOut mirrors the pattern delayed 3 cycles.
- SampleReady=0 throughout, AdcIn=0 -> SampleValid stays 1 and Sample=0. Overrun pulses exactly once per TC from the second sample onward.
- SampleReady asserted exactly on the TC cycle -> new sample loads and SampleValid remains 1 with no Overrun. Ready on a non-TC cycle -> SampleValid drops the next cycle.
- Reset pulsed low mid-window with AdcIn=1 -> all outputs 0 asynchronously. The next sample arrives DECIM+3 cycles after release with full-scale value, not a partial count.
- SD_ADC_SINC2_EN defined, LOG2_DECIM=4, AdcIn=1 -> no valid for the first two windows, then Sample=15. A 50% toggle gives Sample=8.

Source files
------------

// File: rtl/sd_adc_decim_pkg.sv
// Shared constants and width helpers for the delta-sigma ADC decimator.
// These width expressions are kept in step with the companion 1-bit DAC.
// Build option: SD_ADC_SINC2_EN (default: undefined). When defined, the
// decimator uses a second-order CIC instead of the first-order boxcar.
package sd_adc_decim_pkg;

    // Default log2 of the decimation ratio (legal range 2..12).
    localparam int LOG2_DECIM_DEF = 8;

    // Bitstream clocks spent filling the input path (two synchronizer flops
    // plus the feedback flop) before the first counted window begins.
    localparam int WARMUP_CYC = 3;

    // Decimation ratio for a given log2 ratio.
    function automatic int decim_of(input int log2_decim);
        return 1 << log2_decim;
    endfunction

    // Boxcar accumulator width: must hold 0..DECIM inclusive.
    function automatic int acc_w(input int log2_decim);
        return log2_decim + 1;
    endfunction

    // CIC integrator width: must hold 0..DECIM^2 without ambiguity after wrap.
    function automatic int cic_w(input int log2_decim);
        return 2 * log2_decim + 1;
    endfunction

    // Saturated output width: one code short of the full-scale count.
    function automatic int sat_w(input int log2_decim);
        return log2_decim;
    endfunction

endpackage

// File: rtl/sd_adc_decim_sync2.sv
// Two-flop synchronizer with asynchronous active-low reset. Brings a raw
// asynchronous pin into the clock domain. It is shared by other blocks that
// also sample asynchronous pins.
module sd_sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    // Two back-to-back flops give the first stage a full cycle to resolve.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/sd_adc_decim.sv
// First-order delta-sigma ADC receiver. An external comparator drives AdcIn;
// the synchronized bit is fed back through FbOut to close the modulator loop.
// The bitstream is decimated by 2^LOG2_DECIM into unsigned OUT_W-bit samples
// on a valid/ready interface with an overrun flag.
// Build option: SD_ADC_SINC2_EN selects a second-order CIC decimator;
// undefined (default) selects the first-order boxcar.
module sd_adc_decim
    import sd_adc_decim_pkg::*;
#(
    parameter int LOG2_DECIM = LOG2_DECIM_DEF,
    parameter int OUT_W      = LOG2_DECIM
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             AdcIn,
    output logic             FbOut,
    output logic [OUT_W-1:0] Sample,
    output logic             SampleValid,
    input  logic             SampleReady,
    output logic             Overrun
);

    localparam int DECIM = decim_of(LOG2_DECIM);
    localparam int ACC_W = acc_w(LOG2_DECIM);
    localparam int SMP_W = sat_w(LOG2_DECIM);

    // ------------------------------------------------------------------
    // Input path and feedback
    // ------------------------------------------------------------------
    logic bit_s2;
    logic fb_q;

    sd_sync2 u_sync (
        .clk_i  (Clk),
        .rst_ni (Reset),
        .d_i    (AdcIn),
        .q_o    (bit_s2)
    );

    // Feedback always follows the synchronized bit; it is never gated so
    // the external loop keeps modulating even while a sample is pending.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            fb_q <= 1'b0;
        end else begin
            fb_q <= bit_s2;
        end
    end

    assign FbOut = fb_q;

    // ------------------------------------------------------------------
    // Window timing: warm-up, then a free-running phase counter
    // ------------------------------------------------------------------
    // The synchronizer holds reset zeros for its first cycles after release.
    // Counting starts only once those have flushed, so the first window is a
    // full window of real bits and lands DECIM+3 cycles after release.
    logic [1:0]            warm_q, warm_d;
    logic                  run;
    logic [LOG2_DECIM-1:0] ph_q, ph_d;
    logic                  tc;

    assign run = (warm_q == 2'(WARMUP_CYC));
    assign tc  = run && (ph_q == {LOG2_DECIM{1'b1}});

    // Next-state for warm-up and phase counters; the phase wraps naturally.
    always_comb begin
        warm_d = warm_q;
        ph_d   = ph_q;
        if (run) begin
            ph_d = ph_q + 1'b1;
        end else begin
            warm_d = warm_q + 2'd1;
        end
    end

    // Timing state registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            warm_q <= 2'd0;
            ph_q   <= '0;
        end else begin
            warm_q <= warm_d;
            ph_q   <= ph_d;
        end
    end

    // ------------------------------------------------------------------
    // Decimation filter
    // ------------------------------------------------------------------
    logic [SMP_W-1:0] win_smp;   // saturated result of the window closing now
    logic             emit;      // window result is trustworthy

`ifdef SD_ADC_SINC2_EN
    localparam int CIC_W = cic_w(LOG2_DECIM);

    logic [CIC_W-1:0] i1_q, i1_d;
    logic [CIC_W-1:0] i2_q, i2_d;
    logic [CIC_W-1:0] z1_q, z1_d;
    logic [CIC_W-1:0] z2_q, z2_d;
    logic [CIC_W-1:0] comb;
    logic [1:0]       settle_q, settle_d;

    // The comb output peaks at exactly DECIM^2, the only value with the top
    // bit set; that maps to full scale, otherwise drop the LOG2_DECIM LSBs.
    function automatic logic [SMP_W-1:0] sat_cic(input logic [CIC_W-1:0] c);
        logic [CIC_W-1:0] sh;
        sh = c >> LOG2_DECIM;
        if (c[CIC_W-1]) begin
            return '1;
        end
        return sh[SMP_W-1:0];
    endfunction

    // Integrators include the current bit; combs take a second difference
    // of I2 across windows. Modular wrap cancels in the differences.
    always_comb begin
        i1_d     = i1_q;
        i2_d     = i2_q;
        z1_d     = z1_q;
        z2_d     = z2_q;
        settle_d = settle_q;
        if (run) begin
            i1_d = i1_q + CIC_W'(bit_s2);
            i2_d = i2_q + i1_d;
        end
        comb = i2_d - (z1_q << 1) + z2_q;
        if (tc) begin
            z1_d = i2_d;
            z2_d = z1_q;
            if (settle_q != 2'd2) begin
                settle_d = settle_q + 2'd1;
            end
        end
    end

    // CIC integrator, comb delay and settling registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            i1_q     <= '0;
            i2_q     <= '0;
            z1_q     <= '0;
            z2_q     <= '0;
            settle_q <= 2'd0;
        end else begin
            i1_q     <= i1_d;
            i2_q     <= i2_d;
            z1_q     <= z1_d;
            z2_q     <= z2_d;
            settle_q <= settle_d;
        end
    end

    // The first two windows feed comb delays that still hold reset zeros.
    assign emit    = (settle_q == 2'd2);
    assign win_smp = sat_cic(comb);
`else
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] win_r;

    // R lies in 0..DECIM; only R==DECIM sets the top bit and saturates.
    function automatic logic [SMP_W-1:0] sat_box(input logic [ACC_W-1:0] r);
        if (r[ACC_W-1]) begin
            return '1;
        end
        return r[SMP_W-1:0];
    endfunction

    // The window result includes the bit arriving on the terminal cycle.
    assign win_r = acc_q + ACC_W'(bit_s2);

    // Accumulate during the window, restart from zero on the terminal cycle.
    always_comb begin
        acc_d = acc_q;
        if (run) begin
            acc_d = tc ? '0 : win_r;
        end
    end

    // Boxcar accumulator register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign emit    = 1'b1;
    assign win_smp = sat_box(win_r);
`endif

    // ------------------------------------------------------------------
    // Output register and valid/ready handshake
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] smp_q, smp_d;
    logic             vld_q, vld_d;
    logic             ovr_q, ovr_d;

    // A consume clears valid; a new window result overrides that and, if the
    // old sample was neither consumed nor already gone, flags an overrun.
    always_comb begin
        smp_d = smp_q;
        vld_d = vld_q;
        ovr_d = 1'b0;
        if (vld_q && SampleReady) begin
            vld_d = 1'b0;
        end
        if (tc && emit) begin
            smp_d = OUT_W'(win_smp);
            vld_d = 1'b1;
            ovr_d = vld_q && !SampleReady;
        end
    end

    // Output registers; overrun is a single-cycle pulse.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            smp_q <= '0;
            vld_q <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            smp_q <= smp_d;
            vld_q <= vld_d;
            ovr_q <= ovr_d;
        end
    end

    assign Sample      = smp_q;
    assign SampleValid = vld_q;
    assign Overrun     = ovr_q;

endmodule

// File: tb/tb_sd_adc_decim.sv
// Directed bench for sd_adc_decim with LOG2_DECIM=4 (DECIM=16). Expected
// events are queued per test with the cycle (counted from reset release)
// at which they must be observed; they are popped and compared on the
// falling edge after that rising edge.
module tb_sd_adc_decim;

    localparam int L2 = 4;
    localparam int D  = 16;
`ifdef SD_ADC_SINC2_EN
    localparam int FIRST = 3 * D + 3;
`else
    localparam int FIRST = D + 3;
`endif

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic          AdcIn = 1'b0;
    logic          SampleReady = 1'b0;
    logic          FbOut;
    logic [L2-1:0] Sample;
    logic          SampleValid;
    logic          Overrun;

    sd_adc_decim #(.LOG2_DECIM(L2), .OUT_W(L2)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .AdcIn       (AdcIn),
        .FbOut       (FbOut),
        .Sample      (Sample),
        .SampleValid (SampleValid),
        .SampleReady (SampleReady),
        .Overrun     (Overrun)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int    cyc;
        int    v;
        int    s;
        int    o;
        int    f;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    bit   toggle = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input int want);
        n_chk++;
        assert (obs === 32'(want)) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    endtask

    // -1 in any field means "not checked at this cycle".
    function automatic void push(input int c, input string t, input int v,
                                 input int s, input int o, input int f);
        exp_t e;
        e.cyc = c; e.tag = t; e.v = v; e.s = s; e.o = o; e.f = f;
        sb.push_back(e);
    endfunction

    task automatic run_to(input int c);
        while (cyc < c) begin
            @(posedge Clk);
            cyc++;
            @(negedge Clk);
            while (sb.size() > 0 && sb[0].cyc == cyc) begin
                exp_t e;
                e = sb.pop_front();
                if (e.v >= 0) chk({e.tag, ".valid"}, 32'(SampleValid), e.v);
                if (e.s >= 0) chk({e.tag, ".sample"}, 32'(Sample), e.s);
                if (e.o >= 0) chk({e.tag, ".overrun"}, 32'(Overrun), e.o);
                if (e.f >= 0) chk({e.tag, ".fbout"}, 32'(FbOut), e.f);
            end
            if (toggle) AdcIn = ~AdcIn;
        end
    endtask

    task automatic drain(input string tag);
        chk({tag, ".drained"}, 32'(sb.size()), 0);
        sb.delete();
    endtask

    task automatic apply_reset(input logic adc, input logic rdy, input bit tgl);
        @(negedge Clk);
        Reset = 1'b0;
        toggle = 1'b0;
        AdcIn = adc;
        SampleReady = rdy;
        repeat (2) @(negedge Clk);
        toggle = tgl;
        Reset = 1'b1;
        cyc = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state with reset held low across several edges
        AdcIn = 1'b1;
        SampleReady = 1'b1;
        repeat (3) @(negedge Clk);
        chk("rst.fbout", 32'(FbOut), 0);
        chk("rst.sample", 32'(Sample), 0);
        chk("rst.valid", 32'(SampleValid), 0);
        chk("rst.overrun", 32'(Overrun), 0);

        // A: constant ones, always ready -> full scale every window
        apply_reset(1'b1, 1'b1, 1'b0);
        push(2, "A.fb2", -1, -1, -1, 0);
        push(3, "A.fb3", -1, -1, -1, 1);
        push(FIRST - 1, "A.pre", 0, -1, 0, -1);
        push(FIRST, "A.first", 1, 15, 0, 1);
        push(FIRST + 1, "A.drop", 0, -1, 0, -1);
        push(FIRST + D, "A.second", 1, 15, 0, 1);
        run_to(FIRST + D);
        drain("A");

        // B: alternating input -> mid-scale; feedback delayed by 3 clocks
        apply_reset(1'b0, 1'b1, 1'b1);
        push(10, "B.fb10", -1, -1, -1, 1);
        push(11, "B.fb11", -1, -1, -1, 0);
        push(12, "B.fb12", -1, -1, -1, 1);
        push(FIRST, "B.first", 1, 8, 0, -1);
        push(FIRST + D, "B.second", 1, 8, 0, -1);
        run_to(FIRST + D);
        drain("B");

        // C: zeros, never ready -> valid held, overrun once per later window
        apply_reset(1'b0, 1'b0, 1'b0);
        push(FIRST - 1, "C.pre", 0, -1, 0, -1);
        push(FIRST, "C.first", 1, 0, 0, -1);
        push(FIRST + 1, "C.hold", 1, 0, 0, -1);
        push(FIRST + D, "C.ovr1", 1, 0, 1, -1);
        push(FIRST + D + 1, "C.ovr1_end", 1, 0, 0, -1);
        push(FIRST + 2 * D, "C.ovr2", 1, 0, 1, -1);
        push(FIRST + 2 * D + 1, "C.ovr2_end", 1, 0, 0, -1);
        run_to(FIRST + 2 * D + 1);
        drain("C");

        // D: ready exactly on the terminal cycle, then on a non-terminal one
        apply_reset(1'b1, 1'b0, 1'b0);
        push(FIRST, "D.first", 1, 15, 0, -1);
        push(FIRST + D, "D.tc_ready", 1, 15, 0, -1);
        push(FIRST + D + 1, "D.hold", 1, -1, 0, -1);
        push(FIRST + D + 4, "D.drop", 0, -1, 0, -1);
        run_to(FIRST + D - 1);
        SampleReady = 1'b1;
        run_to(FIRST + D);
        SampleReady = 1'b0;
        run_to(FIRST + D + 3);
        SampleReady = 1'b1;
        run_to(FIRST + D + 4);
        SampleReady = 1'b0;
        drain("D");

        // E: reset asserted mid-window clears outputs without a clock edge
        apply_reset(1'b1, 1'b1, 1'b0);
        push(FIRST, "E.first", 1, 15, 0, 1);
        run_to(FIRST + 5);
        drain("E.pre");
        #2;
        Reset = 1'b0;
        #1;
        chk("E.async.fbout", 32'(FbOut), 0);
        chk("E.async.sample", 32'(Sample), 0);
        chk("E.async.valid", 32'(SampleValid), 0);
        chk("E.async.overrun", 32'(Overrun), 0);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        cyc = 0;
        push(FIRST - 1, "E.pre_restart", 0, -1, 0, -1);
        push(FIRST, "E.restart", 1, 15, 0, -1);
        run_to(FIRST);
        drain("E");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
